// File: rtl/xnor_popcount_accumulator.sv
// XNOR/popcount neuron accumulator for the binarized MNIST accelerator.
// Each accepted beat adds the signed match count of LANES activation/weight
// pairs to a saturating accumulator. After cfg_beats beats the result is
// presented through a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no neuron in progress, waiting for start
// ACCUM | accepting beats, counting down the remaining beats
// DONE  | result held on out_acc/out_bit/out_sat until the consumer takes it
module xnor_popcount_accumulator #(
    parameter int LANES  = 8,
    parameter int ACC_W  = 12,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BEAT_W-1:0] cfg_beats,
    input  logic [ACC_W-1:0]  cfg_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES-1:0]  in_x,
    input  logic [LANES-1:0]  in_w,
    input  logic [LANES-1:0]  in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_bit,
    output logic              out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturation bounds, expressed at ACC_W+1 bits so the unclamped sum fits.
    localparam logic [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic               start_take;
    logic               accept;
    logic               last_beat;
    logic [ACC_W:0]     match_cnt;
    logic [ACC_W:0]     mask_cnt;
    logic [ACC_W:0]     delta;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_clamp;
    logic               clamp_hit;
    logic [ACC_W-1:0]   acc;
    logic [BEAT_W-1:0]  count;
    logic               sat;

    function automatic logic [ACC_W:0] popcount(input logic [LANES-1:0] v);
        logic [ACC_W:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + (ACC_W+1)'(v[i]);
        end
        return n;
    endfunction

    // A start is honoured from IDLE, or from DONE when the held result is taken on the same edge.
    assign start_take = start && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept     = in_valid && (state == ACCUM);
    assign last_beat  = accept && (count == BEAT_W'(1));

    // Per-beat signed popcount and saturating sum.
    always_comb begin
        match_cnt = popcount(~(in_x ^ in_w) & in_mask);
        mask_cnt  = popcount(in_mask);
        delta     = (match_cnt << 1) - mask_cnt;
        acc_sum   = {acc[ACC_W-1], acc} + delta;
        acc_clamp = acc_sum[ACC_W-1:0];
        clamp_hit = 1'b0;
        if ($signed(acc_sum) > $signed(ACC_MAX)) begin
            acc_clamp = ACC_MAX[ACC_W-1:0];
            clamp_hit = 1'b1;
        end else if ($signed(acc_sum) < $signed(ACC_MIN)) begin
            acc_clamp = ACC_MIN[ACC_W-1:0];
            clamp_hit = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_take) begin
                    state_next = (cfg_beats == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start_take) begin
                    state_next = (cfg_beats == '0) ? DONE : ACCUM;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
    end

    // Accumulator, beat counter, sticky saturation flag and held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            count   <= '0;
            sat     <= 1'b0;
            out_acc <= '0;
            out_bit <= 1'b0;
            out_sat <= 1'b0;
        end else if (start_take) begin
            acc   <= cfg_bias;
            count <= cfg_beats;
            sat   <= 1'b0;
            if (cfg_beats == '0) begin
                out_acc <= cfg_bias;
                out_bit <= ~cfg_bias[ACC_W-1];
                out_sat <= 1'b0;
            end
        end else if (accept) begin
            acc   <= acc_clamp;
            count <= count - BEAT_W'(1);
            sat   <= sat | clamp_hit;
            if (last_beat) begin
                out_acc <= acc_clamp;
                out_bit <= ~acc_clamp[ACC_W-1];
                out_sat <= sat | clamp_hit;
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Directed bench for xnor_popcount_accumulator with a result scoreboard.
module tb_xnor_popcount_accumulator;

    localparam int LANES  = 8;
    localparam int ACC_W  = 12;
    localparam int BEAT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [BEAT_W-1:0] cfg_beats;
    logic [ACC_W-1:0]  cfg_bias;
    logic              in_valid;
    logic              in_ready;
    logic [LANES-1:0]  in_x;
    logic [LANES-1:0]  in_w;
    logic [LANES-1:0]  in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_bit;
    logic              out_sat;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             bt;
        logic             sat;
    } res_t;

    res_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] bx[16];
    logic [7:0] bw[16];
    logic [7:0] bm[16];

    xnor_popcount_accumulator #(.LANES(LANES), .ACC_W(ACC_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_beats(cfg_beats), .cfg_bias(cfg_bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_bit(out_bit),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    function automatic int model_delta(input logic [7:0] x, input logic [7:0] w, input logic [7:0] m);
        int mt = 0;
        int a  = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                a++;
                if (x[i] == w[i]) mt++;
            end
        end
        return 2 * mt - a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: models the neuron, pushes the expectation, pulses start.
    task automatic start_neuron(input int bias, input int nb);
        int   a = bias;
        logic s = 1'b0;
        res_t r;
        for (int k = 0; k < nb; k++) begin
            a += model_delta(bx[k], bw[k], bm[k]);
            if (a > 2047)  begin a = 2047;  s = 1'b1; end
            if (a < -2048) begin a = -2048; s = 1'b1; end
        end
        r.acc = a[ACC_W-1:0];
        r.bt  = (a >= 0);
        r.sat = s;
        sb.push_back(r);
        start     = 1'b1;
        cfg_beats = nb[BEAT_W-1:0];
        cfg_bias  = bias[ACC_W-1:0];
        @(negedge clk);
        start     = 1'b0;
        cfg_beats = $urandom_range(0, 255);
        cfg_bias  = $urandom_range(0, 4095);
    endtask

    // Drives nb beats; an idle cycle is inserted before beat index bubble_at.
    task automatic feed_beats(input string tag, input int nb, input int bubble_at);
        for (int k = 0; k < nb; k++) begin
            if (k == bubble_at) begin
                in_valid = 1'b0;
                in_x     = $urandom_range(0, 255);
                in_w     = $urandom_range(0, 255);
                in_mask  = 8'hFF;
                @(negedge clk);
            end
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_x     = bx[k];
            in_w     = bw[k];
            in_mask  = bm[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Checks one-cycle latency, then pops the scoreboard and compares the result.
    task automatic expect_result(input string tag, output res_t got);
        int n = 0;
        chk({tag, "_latency"}, 32'(out_valid), 32'd1);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
        got = sb.pop_front();
        chk({tag, "_acc"}, 32'(out_acc), 32'(got.acc));
        chk({tag, "_bit"}, 32'(out_bit), 32'(got.bt));
        chk({tag, "_sat"}, 32'(out_sat), 32'(got.sat));
    endtask

    // With out_ready high the result is taken; outputs must retain their values.
    task automatic after_handshake(input string tag, input res_t r);
        @(negedge clk);
        chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_acc_kept"}, 32'(out_acc), 32'(r.acc));
    endtask

    initial begin
        res_t r;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_beats = '0;
        cfg_bias  = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_mask   = '0;
        out_ready = 1'b1;

        // Reset with random inputs.
        for (int c = 0; c < 6; c++) begin
            start     = $urandom_range(0, 1);
            cfg_beats = $urandom_range(0, 255);
            cfg_bias  = $urandom_range(0, 4095);
            in_valid  = $urandom_range(0, 1);
            in_x      = $urandom_range(0, 255);
            in_w      = $urandom_range(0, 255);
            in_mask   = $urandom_range(0, 255);
            out_ready = $urandom_range(0, 1);
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_acc", 32'(out_acc), 32'd0);
            chk("rst_out_bit", 32'(out_bit), 32'd0);
            chk("rst_out_sat", 32'(out_sat), 32'd0);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // All-match, three beats, no bias.
        for (int k = 0; k < 3; k++) begin bx[k] = 8'hFF; bw[k] = 8'hFF; bm[k] = 8'hFF; end
        start_neuron(0, 3);
        feed_beats("match3", 3, -1);
        expect_result("match3", r);
        after_handshake("match3", r);

        // Mixed deltas -8,+4 with bias 5 and then 2; first run has a bubble.
        bx[0] = 8'h0F; bw[0] = 8'hF0; bm[0] = 8'hFF;
        bx[1] = 8'hAA; bw[1] = 8'hAA; bm[1] = 8'h0F;
        start_neuron(5, 2);
        feed_beats("mix_b5", 2, 1);
        expect_result("mix_b5", r);
        after_handshake("mix_b5", r);
        start_neuron(2, 2);
        feed_beats("mix_b2", 2, -1);
        expect_result("mix_b2", r);
        after_handshake("mix_b2", r);

        // Positive and negative saturation.
        for (int k = 0; k < 2; k++) begin bx[k] = 8'hFF; bw[k] = 8'hFF; bm[k] = 8'hFF; end
        start_neuron(2040, 2);
        feed_beats("sat_pos", 2, -1);
        expect_result("sat_pos", r);
        after_handshake("sat_pos", r);
        for (int k = 0; k < 2; k++) begin bx[k] = 8'hFF; bw[k] = 8'h00; bm[k] = 8'hFF; end
        start_neuron(-2040, 2);
        feed_beats("sat_neg", 2, -1);
        expect_result("sat_neg", r);
        after_handshake("sat_neg", r);

        // Back-pressure: result held, start ignored, then back-to-back start.
        bx[0] = 8'h3C; bw[0] = 8'h35; bm[0] = 8'hF7;
        out_ready = 1'b0;
        start_neuron(100, 1);
        feed_beats("hold", 1, -1);
        expect_result("hold", r);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start     = 1'b1;
                cfg_beats = 8'd1;
                cfg_bias  = 12'd50;
            end
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_acc", 32'(out_acc), 32'(r.acc));
            chk("hold_bit", 32'(out_bit), 32'(r.bt));
            chk("hold_sat", 32'(out_sat), 32'(r.sat));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        bx[0] = 8'h00; bw[0] = 8'hFF; bm[0] = 8'h81;
        start_neuron(-20, 1);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_valid_low", 32'(out_valid), 32'd0);
        feed_beats("b2b", 1, -1);
        expect_result("b2b", r);
        after_handshake("b2b", r);

        // Zero-beat neuron returns the bias.
        start_neuron(-7, 0);
        expect_result("zero_beat", r);
        after_handshake("zero_beat", r);

        // Leave a saturated result visible, then reset during beat 2 of 4.
        for (int k = 0; k < 2; k++) begin bx[k] = 8'hFF; bw[k] = 8'hFF; bm[k] = 8'hFF; end
        start_neuron(2047, 2);
        feed_beats("pre_rst", 2, -1);
        expect_result("pre_rst", r);
        after_handshake("pre_rst", r);
        for (int k = 0; k < 4; k++) begin bx[k] = 8'hFF; bw[k] = 8'hFF; bm[k] = 8'hFF; end
        start_neuron(10, 4);
        in_valid = 1'b1; in_x = bx[0]; in_w = bw[0]; in_mask = bm[0];
        @(negedge clk);
        in_x  = bx[1];
        rst_n = 1'b0;
        @(negedge clk);
        void'(sb.pop_back());
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc", 32'(out_acc), 32'd0);
        chk("mid_rst_bit", 32'(out_bit), 32'd0);
        chk("mid_rst_sat", 32'(out_sat), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        bx[0] = 8'h01; bw[0] = 8'h01; bm[0] = 8'h01;
        start_neuron(3, 1);
        feed_beats("post_rst", 1, -1);
        expect_result("post_rst", r);
        after_handshake("post_rst", r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
